ahfp_div: RTL and testbench

Multi-cycle IEEE-754 single-precision floating-point divider, the inverse-operation companion to the team's floating-point multiplier. It computes result = dataa / datab with a radix-2 restoring mantissa divider, round-to-nearest-even, and full special-case handling. It sits on the processor's multi-cycle custom-instruction port and uses the start/done handshake and clk_en stall semantics.

---
 rtl/ahfp_div.sv | 181 ++++++++++++++++++
 tb/tb_ahfp_div.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_div.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa divide,
// round-to-nearest-even, flush-to-zero, start/done handshake with clk_en stall.
module ahfp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int unsigned BIAS = 127;
    localparam int unsigned ITER = 26;
    localparam int unsigned QW   = 26;
    localparam int unsigned MW   = 24;
    localparam int unsigned EW   = 10;
    localparam int unsigned CW   = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [QW-1:0]       r_q, w_q_nxt;
    logic [QW-1:0]       r_rem, w_rem_nxt;
    logic [MW-1:0]       r_mb, w_mb_nxt;
    logic signed [EW-1:0] r_exp, w_exp_nxt;
    logic                r_sign, w_sign_nxt;
    logic                r_special, w_special_nxt;
    logic [31:0]         r_spec_res, w_spec_res_nxt;
    logic [31:0]         r_result, w_result_nxt;
    logic                r_done, w_done_nxt;

    // Operand classification; exponent-0 inputs count as signed zero
    logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic w_sign_in, w_nan, w_inf, w_zero, w_spec_hit;
    logic [31:0] w_spec_val;
    logic signed [EW-1:0] w_exp0;

    assign w_a_zero  = (dataa[30:23] == 8'h00);
    assign w_a_inf   = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'h0);
    assign w_a_nan   = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'h0);
    assign w_b_zero  = (datab[30:23] == 8'h00);
    assign w_b_inf   = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'h0);
    assign w_b_nan   = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'h0);
    assign w_sign_in = dataa[31] ^ datab[31];

    assign w_nan      = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_inf      = w_a_inf | w_b_zero;
    assign w_zero     = w_a_zero | w_b_inf;
    assign w_spec_hit = w_nan | w_inf | w_zero;
    assign w_spec_val = w_nan ? 32'h7FC0_0000 :
                        w_inf ? {w_sign_in, 8'hFF, 23'h0} :
                                {w_sign_in, 31'h0};

    assign w_exp0 = signed'({2'b00, dataa[30:23]}) - signed'({2'b00, datab[30:23]})
                  + signed'(EW'(BIAS));

    // One restoring-division step
    logic          w_ge;
    logic [QW-1:0] w_diff, w_rem_step;

    assign w_ge       = (r_rem >= {2'b00, r_mb});
    assign w_diff     = r_rem - {2'b00, r_mb};
    assign w_rem_step = w_ge ? {w_diff[QW-2:0], 1'b0} : {r_rem[QW-2:0], 1'b0};

    // Normalise and round the finished quotient
    logic [22:0]          w_mant;
    logic                 w_guard, w_sticky, w_inc;
    logic [23:0]          w_mant_inc;
    logic signed [EW-1:0] w_e_norm, w_e_fin;
    logic [31:0]          w_rounded;

    always_comb begin
        w_mant   = r_q[23:1];
        w_guard  = r_q[0];
        w_sticky = |r_rem;
        w_e_norm = r_exp - 10'sd1;
        if (r_q[QW-1]) begin
            w_mant   = r_q[24:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (|r_rem);
            w_e_norm = r_exp;
        end
    end

    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + 24'(w_inc);
    assign w_e_fin    = w_e_norm + signed'({9'd0, w_mant_inc[23]});

    always_comb begin
        w_rounded = {r_sign, w_e_fin[7:0], w_mant_inc[22:0]};
        if (w_e_fin >= 10'sd255) begin
            w_rounded = {r_sign, 8'hFF, 23'h0};
        end else if (w_e_fin <= 10'sd0) begin
            w_rounded = {r_sign, 31'h0};
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_q_nxt        = r_q;
        w_rem_nxt      = r_rem;
        w_mb_nxt       = r_mb;
        w_exp_nxt      = r_exp;
        w_sign_nxt     = r_sign;
        w_special_nxt  = r_special;
        w_spec_res_nxt = r_spec_res;
        w_result_nxt   = r_result;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_special_nxt  = w_spec_hit;
                    w_spec_res_nxt = w_spec_val;
                    w_sign_nxt     = w_sign_in;
                    w_exp_nxt      = w_exp0;
                    w_mb_nxt       = {1'b1, datab[22:0]};
                    w_rem_nxt      = {2'b00, 1'b1, dataa[22:0]};
                    w_q_nxt        = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = w_spec_hit ? S_ROUND : S_DIV;
                end
            end
            S_DIV: begin
                w_q_nxt   = {r_q[QW-2:0], w_ge};
                w_rem_nxt = w_rem_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(ITER - 1)) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_result_nxt = r_special ? r_spec_res : w_rounded;
                w_done_nxt   = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; clk_en low freezes everything including done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_mb       <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else if (clk_en) begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_q        <= w_q_nxt;
            r_rem      <= w_rem_nxt;
            r_mb       <= w_mb_nxt;
            r_exp      <= w_exp_nxt;
            r_sign     <= w_sign_nxt;
            r_special  <= w_special_nxt;
            r_spec_res <= w_spec_res_nxt;
            r_result   <= w_result_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule

// File: tb/tb_ahfp_div.sv
// Scoreboard bench for ahfp_div: directed spec vectors plus random operands
// checked against an exact integer-arithmetic reference divider.
module tb_ahfp_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_done = 1'b0;

    ahfp_div dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every rising done pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_done result=%h cyc=%0d", result, cyc);
            end else begin
                e = sb.pop_front();
                total = total + 1;
                if (result !== e.res) begin
                    bad = bad + 1;
                    $display("FAIL result got=%h want=%h cyc=%0d", result, e.res, cyc);
                end
                total = total + 1;
                if (cyc != e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
                end
            end
        end
        prev_done = done;
    end

    // Exact reference: wide integer quotient, generic RNE on the leading 24 bits
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output int lat);
        logic s, a0, b0, ai, bi, an, bn, guard, sticky;
        int ea, eb, e, p;
        longint unsigned ma, mb, n, q, r, sig, mask;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a0 = (ea == 0);
        b0 = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'h0);
        bi = (eb == 255) && (b[22:0] == 23'h0);
        an = (ea == 255) && (a[22:0] != 23'h0);
        bn = (eb == 255) && (b[22:0] != 23'h0);
        lat = 1;
        if (an || bn || (a0 && b0) || (ai && bi)) return 32'h7FC0_0000;
        if (ai || b0) return {s, 8'hFF, 23'h0};
        if (a0 || bi) return {s, 31'h0};
        lat = 27;
        ma = {40'h0, 1'b1, a[22:0]};
        mb = {40'h0, 1'b1, b[22:0]};
        n  = ma << 40;
        q  = n / mb;
        r  = n % mb;
        p  = 0;
        for (int i = 0; i < 64; i++) if (q[i]) p = i;
        sig    = q >> (p - 23);
        guard  = q[p - 24];
        mask   = (64'd1 << (p - 24)) - 64'd1;
        sticky = ((q & mask) != 64'd0) || (r != 64'd0);
        e = ea - eb + 127 + (p - 40);
        if (guard && (sticky || sig[0])) sig = sig + 64'd1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        k = int'($urandom_range(0, 15));
        v = $urandom;
        case (k)
            0:       v[30:0] = 31'h0;
            1:       v[30:23] = 8'h00;
            2:       begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
            3:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            4:       v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01;
            13, 14, 15: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat, input int stall);
        exp_t e;
        dataa = a;
        datab = b;
        start = 1'b1;
        e.res = exp_res;
        e.cyc = cyc + 1 + lat + stall;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    logic [31:0] da[9] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                           32'h7F800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] db[9] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                           32'h7F800000, 32'h40000000, 32'h3E800000, 32'h40000000};
    logic [31:0] dr[9] = '{32'h40400000, 32'hC0400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
                           32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
    int          dl[9] = '{27, 27, 27, 1, 1, 1, 1, 27, 27};

    initial begin
        logic [31:0] a, b, r;
        int lat;
        reset  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            issue(da[i], db[i], dr[i], dl[i], 0);
            wait_idle();
        end

        // Pending done must hold while clk_en is low
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
        @(negedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_hold", {31'h0, done}, 32'h1);
        end
        clk_en = 1'b1;
        @(negedge clk);
        check("done_clear", {31'h0, done}, 32'h0);
        wait_idle();

        // Stall mid-DIV plus an ignored second start
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27, 5);
        repeat (3) @(negedge clk);
        dataa = 32'h3F800000;
        datab = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        wait_idle();

        // Reset abort mid-operation
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            a = rand_op();
            b = rand_op();
            r = ref_div(a, b, lat);
            issue(a, b, r, lat, 0);
            wait_idle();
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
